udp_tx_packetizer: RTL and testbench



---
 rtl/udp_tx_packetizer_pkg.sv | 18 +
 rtl/udp_tx_packetizer_flush_timer.sv | 34 +++
 rtl/udp_tx_packetizer.sv | 146 ++++++++++++++
 tb/tb_udp_tx_packetizer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_packetizer_pkg.sv
// Shared types and constants for the UDP TX packetizer.
package udp_tx_packetizer_pkg;

  localparam int SEQ_W        = 16;
  localparam int RECORD_BYTES = 4;
  localparam int HDR_BYTES    = 2;
  localparam int IDX_W        = $clog2(RECORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_BODY,
    ST_HOLD,
    ST_LAST
  } state_e;

endpackage

// File: rtl/udp_tx_packetizer_flush_timer.sv
// Idle timer for the record-boundary flush: clear on load, count while
// enabled, saturate instead of wrapping, flag expiry at TIMEOUT-1.
module udp_flush_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != W'(TIMEOUT)))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q >= W'(TIMEOUT - 1));

endmodule

// File: rtl/udp_tx_packetizer.sv
// Frames 4-byte records from an FWFT FIFO into UDP payloads:
// 16-bit big-endian sequence number followed by 1..MAX_RECORDS records.
// The last byte of each record is parked in a holding register so the
// packet can be closed (tlast) on it without ever splitting a record.
module udp_tx_packetizer
  import udp_tx_packetizer_pkg::*;
#(
  parameter int MAX_RECORDS   = 64,
  parameter int FLUSH_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_fifo_tdata,
  input  logic             s_fifo_tvalid,
  output logic             s_fifo_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [SEQ_W-1:0] seq_num,
  output logic             timeout_flush
);

  state_e           state_q;
  logic [SEQ_W-1:0] seq_q;
  logic [7:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       held_q;
  logic             commit_q;
  logic             tflush_q;

  logic last_byte, cnt_full, m_xfer, s_pop, hold_idle, tmr_clr, tmr_exp;

  assign last_byte = (idx_q == IDX_W'(RECORD_BYTES - 1));
  assign cnt_full  = (cnt_q == 8'(MAX_RECORDS));
  assign m_xfer    = m_axis_tvalid && m_axis_tready;
  assign s_pop     = s_fifo_tvalid && s_fifo_tready;
  // Waiting at a record boundary with nothing to send: only then does the timer run.
  assign hold_idle = (state_q == ST_HOLD) && !cnt_full && !s_fifo_tvalid && !commit_q;
  assign tmr_clr   = (state_q == ST_BODY) && last_byte && s_pop;

  udp_flush_timer #(.TIMEOUT(FLUSH_TIMEOUT)) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (tmr_clr),
    .en_i     (hold_idle),
    .expired_o(tmr_exp)
  );

  // Output decode; tvalid is built only from state and FIFO valid, never tready.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_fifo_tready = 1'b0;
    case (state_q)
      ST_HDR_HI: begin
        m_axis_tdata  = seq_q[15:8];
        m_axis_tvalid = 1'b1;
      end
      ST_HDR_LO: begin
        m_axis_tdata  = seq_q[7:0];
        m_axis_tvalid = 1'b1;
      end
      ST_BODY: begin
        if (!last_byte) begin
          m_axis_tdata  = s_fifo_tdata;
          m_axis_tvalid = s_fifo_tvalid;
          s_fifo_tready = m_axis_tready;
        end else begin
          s_fifo_tready = s_fifo_tvalid;
        end
      end
      ST_HOLD: begin
        if (!cnt_full) begin
          m_axis_tdata  = held_q;
          m_axis_tvalid = s_fifo_tvalid || commit_q;
        end
      end
      ST_LAST: begin
        m_axis_tdata  = held_q;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  // Packet FSM with sequence, record count, byte index and held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      seq_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      held_q   <= '0;
      commit_q <= 1'b0;
      tflush_q <= 1'b0;
    end else begin
      tflush_q <= 1'b0;
      case (state_q)
        ST_IDLE:   if (s_fifo_tvalid) state_q <= ST_HDR_HI;
        ST_HDR_HI: if (m_xfer) state_q <= ST_HDR_LO;
        ST_HDR_LO: if (m_xfer) begin
          state_q <= ST_BODY;
          idx_q   <= '0;
        end
        ST_BODY: if (s_pop) begin
          if (last_byte) begin
            held_q  <= s_fifo_tdata;
            cnt_q   <= cnt_q + 8'd1;
            idx_q   <= '0;
            state_q <= ST_HOLD;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_full) begin
            state_q <= ST_LAST;
          end else if (m_xfer) begin
            commit_q <= 1'b0;
            idx_q    <= '0;
            state_q  <= ST_BODY;
          end else if (m_axis_tvalid) begin
            // Held byte offered as a continuation: keep offering it until taken.
            commit_q <= 1'b1;
          end else if (tmr_exp) begin
            state_q  <= ST_LAST;
            tflush_q <= 1'b1;
          end
        end
        ST_LAST: if (m_xfer) begin
          seq_q   <= seq_q + 16'd1;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seq_num       = seq_q;
  assign timeout_flush = tflush_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Bench for udp_tx_packetizer: a FIFO source model, a byte-level
// scoreboard rebuilt from the framing rules, and directed scenarios.
module tb_udp_tx_packetizer;

  localparam int MAX = 64;
  localparam int FT  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_fifo_tdata = 8'h00;
  logic        drv_v = 1'b0;
  logic        s_fifo_tvalid;
  logic        s_fifo_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [15:0] seq_num;
  logic        timeout_flush;

  assign s_fifo_tvalid = drv_v && !rst;

  udp_tx_packetizer #(.MAX_RECORDS(MAX), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst),
    .s_fifo_tdata(s_fifo_tdata), .s_fifo_tvalid(s_fifo_tvalid), .s_fifo_tready(s_fifo_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .seq_num(seq_num), .timeout_flush(timeout_flush)
  );

  always #4 clk = ~clk;

  int errors = 0, checks = 0;

  // source FIFO model: bytes and the cycle each becomes visible
  logic [7:0] src[$];
  int         rel[$];
  int         rd_ptr = 0, exp_ptr = 0, cyc = 0;
  bit         rdy_rand = 0;

  // scoreboard state and logs
  int          pos = 0, pkt_pulses = 0, tlast_cyc = 0, rec_pop_cyc = -1;
  logic [15:0] exp_seq = '0;
  bit          prev_stall = 0, prev_pulse = 0, prev_last = 0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  obs_q[$];
  int          pkt_len_q[$], pkt_pulse_q[$];
  logic [15:0] pkt_hdr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive FIFO head and sink ready shortly after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_ptr < src.size()) begin
      drv_v        = (cyc >= rel[rd_ptr]);
      s_fifo_tdata = src[rd_ptr];
    end else begin
      drv_v        = 1'b0;
      s_fifo_tdata = 8'h00;
    end
    m_axis_tready = rdy_rand ? ($urandom_range(99) < 50) : 1'b1;
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      pos = 0; exp_seq = '0; pkt_pulses = 0; prev_stall = 0; prev_pulse = 0;
      rd_ptr = ((rd_ptr + 3) / 4) * 4;
      if (rd_ptr > src.size()) rd_ptr = src.size();
      exp_ptr = rd_ptr;
    end else begin
      check("seq_num", seq_num, exp_seq);
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", m_axis_tlast, prev_last);
      end
      if (timeout_flush) begin
        check("pulse_width", prev_pulse, 1'b0);
        pkt_pulses++;
      end
      prev_pulse = timeout_flush;
      if (s_fifo_tvalid && s_fifo_tready) begin
        rd_ptr++;
        if (rd_ptr % 4 == 0) rec_pop_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back(m_axis_tdata);
        if (pos == 0) begin
          check("hdr_hi", m_axis_tdata, exp_seq[15:8]);
          check("tlast_hdr", m_axis_tlast, 1'b0);
          pos++;
        end else if (pos == 1) begin
          check("hdr_lo", m_axis_tdata, exp_seq[7:0]);
          check("tlast_hdr", m_axis_tlast, 1'b0);
          pos++;
        end else begin
          int rb, nrec;
          rb   = (pos - 2) % 4;
          nrec = (pos - 2) / 4 + 1;
          if (exp_ptr < src.size()) begin
            check("payload", m_axis_tdata, src[exp_ptr]);
            check("popped_first", exp_ptr < rd_ptr, 1'b1);
            exp_ptr++;
          end else begin
            check("extra_byte", exp_ptr, src.size());
          end
          if (rb != 3)        check("tlast_mid", m_axis_tlast, 1'b0);
          else if (nrec == MAX) check("tlast_max", m_axis_tlast, 1'b1);
          if (m_axis_tlast) begin
            check("close_pulse", pkt_pulses, (nrec < MAX) ? 1 : 0);
            pkt_len_q.push_back(pos + 1);
            pkt_pulse_q.push_back(pkt_pulses);
            pkt_hdr_q.push_back(exp_seq);
            exp_seq++; pos = 0; pkt_pulses = 0; tlast_cyc = cyc;
          end else begin
            pos++;
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic push_rec(input logic [31:0] w, input int r);
    for (int i = 0; i < 4; i++) begin
      src.push_back(w[31-8*i -: 8]);
      rel.push_back(r);
    end
  endtask

  task automatic clear_logs();
    obs_q.delete(); pkt_len_q.delete(); pkt_pulse_q.delete(); pkt_hdr_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_ptr == src.size() && pos == 0) && n < budget) begin
      @(posedge clk); #2; n++;
    end
    check("drain", (exp_ptr == src.size() && pos == 0), 1'b1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    clear_logs();
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_tready"}, s_fifo_tready, 1'b0);
    check({tag, "_tlast"}, m_axis_tlast, 1'b0);
    check({tag, "_tdata"}, m_axis_tdata, 8'h00);
    check({tag, "_seq"}, seq_num, 16'h0000);
    check({tag, "_flush"}, timeout_flush, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_len[3], exp_pul[3], k, n, start, sum;
    logic [7:0] t1[6];
    exp_len = '{258, 258, 10};
    exp_pul = '{0, 0, 1};
    t1 = '{8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("reset");

    // single record then idle: timeout close
    push_rec(32'hDEADBEEF, cyc);
    wait_drain(400);
    check("t1_len", obs_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t1_byte", (i < obs_q.size()) ? obs_q[i] : 8'hxx, t1[i]);
    check("t1_timing", tlast_cyc - rec_pop_cyc, FT + 1);
    check("t1_pulse", pkt_pulse_q.size() > 0 ? pkt_pulse_q[0] : -1, 1);
    check("t1_seq", seq_num, 16'h0001);

    // 130 back-to-back records: two MAX closes and a timeout close
    do_reset();
    for (int i = 0; i < 130; i++) push_rec($urandom, cyc);
    wait_drain(3000);
    check("t2_npkt", pkt_len_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_len", (i < pkt_len_q.size()) ? pkt_len_q[i] : -1, exp_len[i]);
      check("t2_pulse", (i < pkt_pulse_q.size()) ? pkt_pulse_q[i] : -1, exp_pul[i]);
      check("t2_hdr", (i < pkt_hdr_q.size()) ? pkt_hdr_q[i] : 16'hxxxx, i);
    end

    // random backpressure and FIFO gaps
    clear_logs();
    rdy_rand = 1;
    begin
      int r;
      logic [31:0] w;
      r = cyc;
      for (int i = 0; i < 40; i++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) begin
          r += ($urandom_range(7) == 0) ? $urandom_range(40, 5) : $urandom_range(1, 0);
          src.push_back(w[31-8*b -: 8]);
          rel.push_back(r);
        end
      end
    end
    wait_drain(20000);
    sum = 0;
    foreach (pkt_len_q[i]) sum += pkt_len_q[i] - 2;
    check("t3_payload_total", sum, 160);
    rdy_rand = 0;

    // data appears on the timer-expiry cycle: packet continues
    do_reset();
    rec_pop_cyc = -1;
    push_rec(32'h11223344, cyc);
    n = 0;
    while (rec_pop_cyc < 0 && n < 100) begin @(posedge clk); #2; n++; end
    check("t4_pop", rec_pop_cyc >= 0, 1'b1);
    k = rec_pop_cyc;
    push_rec(32'h55667788, k + FT);
    wait_drain(400);
    check("t4_npkt", pkt_len_q.size(), 1);
    check("t4_len", pkt_len_q.size() > 0 ? pkt_len_q[0] : -1, 10);
    check("t4_pulse", pkt_pulse_q.size() > 0 ? pkt_pulse_q[0] : -1, 1);

    // sequence wrap
    do_reset();
    @(posedge clk); #2;
    force dut.seq_q = 16'hFFFF;
    exp_seq = 16'hFFFF;
    @(posedge clk); #2;
    release dut.seq_q;
    push_rec(32'hA1A2A3A4, cyc);
    wait_drain(400);
    push_rec(32'hB1B2B3B4, cyc);
    wait_drain(400);
    check("t5_hi0", obs_q.size() > 1 ? obs_q[0] : 8'hxx, 8'hFF);
    check("t5_lo0", obs_q.size() > 1 ? obs_q[1] : 8'hxx, 8'hFF);
    check("t5_hi1", obs_q.size() > 7 ? obs_q[6] : 8'hxx, 8'h00);
    check("t5_lo1", obs_q.size() > 7 ? obs_q[7] : 8'hxx, 8'h00);
    check("t5_seq", seq_num, 16'h0001);

    // reset in the middle of a record
    start = rd_ptr;
    push_rec(32'hC1C2C3C4, cyc);
    push_rec(32'hD1D2D3D4, cyc);
    n = 0;
    while (rd_ptr != start + 2 && n < 100) begin @(posedge clk); #2; n++; end
    check("t6_reach", rd_ptr, start + 2);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    clear_logs();
    #1 chk_zero("midrst");
    wait_drain(400);
    check("t6_npkt", pkt_len_q.size(), 1);
    check("t6_hdr", pkt_hdr_q.size() > 0 ? pkt_hdr_q[0] : 16'hxxxx, 16'h0000);
    check("t6_len", pkt_len_q.size() > 0 ? pkt_len_q[0] : -1, 6);
    check("t6_b2", obs_q.size() > 2 ? obs_q[2] : 8'hxx, 8'hD1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
